// File: rtl/mmu_addresses_pkg.sv
// Address map constants and bus-owner state encoding shared by the DMA/CPU memory routing logic.
package mmu_addresses_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DMA_OWN = 2'd1,
    RELEASE = 2'd2
  } owner_state_t;

  localparam logic [15:0] HRAM_START  = 16'hFF80;
  localparam logic [15:0] ECHO_BASE   = 16'hE000;
  localparam logic [15:0] ECHO_OFFSET = 16'h2000;
  localparam logic [15:0] OAM_START   = 16'hFE00;
  localparam logic [15:0] OAM_END     = 16'hFE9F;

  // The echo mirror stops where OAM begins, so OAM and the IO page are never folded down.
  function automatic logic [15:0] echo_remap(input logic [15:0] addr);
    if (addr >= ECHO_BASE && addr < OAM_START) begin
      echo_remap = addr - ECHO_OFFSET;
    end else begin
      echo_remap = addr;
    end
  endfunction

  function automatic logic in_oam(input logic [15:0] addr);
    in_oam = (addr >= OAM_START) && (addr <= OAM_END);
  endfunction

endpackage

// File: rtl/dma_mmu_responder.sv
// Arbitrates the main memory port between CPU and DMA, keeps HRAM reachable by the CPU at all times,
// and accounts for CPU accesses dropped while the DMA owns the bus.
module dma_mmu_responder
  import mmu_addresses_pkg::owner_state_t;
  import mmu_addresses_pkg::IDLE;
  import mmu_addresses_pkg::DMA_OWN;
  import mmu_addresses_pkg::RELEASE;
  import mmu_addresses_pkg::echo_remap;
  import mmu_addresses_pkg::in_oam;
#(
  parameter logic [15:0] HRAM_START = mmu_addresses_pkg::HRAM_START,
  parameter logic [7:0]  OPEN_BUS   = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dma_active,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_read_en,
  input  logic        dma_write_en,
  output logic [7:0]  dma_rdata,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_read_en,
  input  logic        cpu_write_en,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] hram_addr,
  output logic [7:0]  hram_wdata,
  output logic        hram_read_en,
  output logic        hram_write_en,
  input  logic [7:0]  hram_rdata,
  output logic        cpu_blocked,
  output logic [7:0]  blocked_count,
  output logic        dma_error
);

  owner_state_t state;
  logic [7:0]   rdata_q;
  logic         dma_owns;
  logic         cpu_access;
  logic         cpu_hram;
  logic         dma_wr_ok;
  logic         dma_wr_bad;

  assign dma_owns   = (state != IDLE);
  assign cpu_access = cpu_read_en | cpu_write_en;
  assign cpu_hram   = (cpu_addr >= HRAM_START);

  // Routing: gated by reset_n so no strobe can leak out while the block is held in reset.
  always_comb begin
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_read_en   = 1'b0;
    mem_write_en  = 1'b0;
    hram_addr     = '0;
    hram_wdata    = '0;
    hram_read_en  = 1'b0;
    hram_write_en = 1'b0;
    cpu_rdata     = OPEN_BUS;
    dma_rdata     = rdata_q;
    cpu_blocked   = 1'b0;
    dma_wr_ok     = 1'b0;
    dma_wr_bad    = 1'b0;
    if (reset_n) begin
      if (cpu_access && cpu_hram) begin
        hram_addr     = cpu_addr;
        hram_read_en  = cpu_read_en;
        hram_write_en = cpu_write_en;
        hram_wdata    = cpu_write_en ? cpu_wdata : 8'h00;
        if (cpu_read_en) cpu_rdata = hram_rdata;
      end else if (cpu_access) begin
        if (!dma_owns) begin
          mem_addr     = cpu_addr;
          mem_read_en  = cpu_read_en;
          mem_write_en = cpu_write_en;
          mem_wdata    = cpu_write_en ? cpu_wdata : 8'h00;
          if (cpu_read_en) cpu_rdata = mem_rdata;
        end else begin
          cpu_blocked = 1'b1;
        end
      end
      if (dma_owns) begin
        // A simultaneous read wins; the write half is treated as illegal.
        dma_wr_ok  = dma_write_en && !dma_read_en && in_oam(dma_addr);
        dma_wr_bad = dma_write_en && !dma_wr_ok;
        if (dma_read_en || dma_wr_ok) begin
          mem_addr     = echo_remap(dma_addr);
          mem_read_en  = dma_read_en;
          mem_write_en = dma_wr_ok;
          mem_wdata    = dma_wr_ok ? dma_wdata : 8'h00;
        end
        if (dma_read_en) dma_rdata = mem_rdata;
      end
    end
  end

  // Ownership FSM, held read data, drop counter and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      rdata_q       <= OPEN_BUS;
      blocked_count <= 8'd0;
      dma_error     <= 1'b0;
    end else begin
      case (state)
        IDLE:    state <= dma_active ? DMA_OWN : IDLE;
        DMA_OWN: state <= dma_active ? DMA_OWN : RELEASE;
        RELEASE: state <= dma_active ? DMA_OWN : IDLE;
        default: state <= IDLE;
      endcase
      if (dma_owns && dma_read_en) rdata_q <= mem_rdata;
      if (state == IDLE && dma_active) begin
        blocked_count <= 8'd0;
      end else if (cpu_blocked && blocked_count != 8'hFF) begin
        blocked_count <= blocked_count + 8'd1;
      end
      if (dma_wr_bad) dma_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_mmu_responder.sv
// Scoreboard bench: a per-cycle reference model pushes expected port values, a negedge monitor compares.
module tb_dma_mmu_responder;

  logic        clk;
  logic        reset_n;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_read_en;
  logic        dma_write_en;
  logic [7:0]  dma_rdata;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_read_en;
  logic        cpu_write_en;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [7:0]  mem_rdata;
  logic [15:0] hram_addr;
  logic [7:0]  hram_wdata;
  logic        hram_read_en;
  logic        hram_write_en;
  logic [7:0]  hram_rdata;
  logic        cpu_blocked;
  logic [7:0]  blocked_count;
  logic        dma_error;

  dma_mmu_responder #(.HRAM_START(16'hFF80), .OPEN_BUS(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .dma_active(dma_active),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_read_en(dma_read_en),
    .dma_write_en(dma_write_en), .dma_rdata(dma_rdata),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read_en(cpu_read_en),
    .cpu_write_en(cpu_write_en), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_rdata(mem_rdata),
    .hram_addr(hram_addr), .hram_wdata(hram_wdata), .hram_read_en(hram_read_en),
    .hram_write_en(hram_write_en), .hram_rdata(hram_rdata),
    .cpu_blocked(cpu_blocked), .blocked_count(blocked_count), .dma_error(dma_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: byte-addressed main memory, HRAM answers with a fixed address hash.
  logic [7:0] mem_arr [0:65535];
  assign mem_rdata  = mem_arr[mem_addr];
  assign hram_rdata = hram_addr[7:0] ^ 8'h3C;

  typedef struct packed {
    logic [15:0] maddr;
    logic [7:0]  mwd;
    logic        mre;
    logic        mwe;
    logic [15:0] haddr;
    logic [7:0]  hwd;
    logic        hre;
    logic        hwe;
    logic [7:0]  crd;
    logic [7:0]  drd;
    logic        blk;
    logic [7:0]  cnt;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference state: bus ownership is "dma_active seen in either of the last two cycles".
  bit         m_a1, m_a2;
  logic [7:0] m_cnt;
  bit         m_err;
  logic [7:0] m_rq;
  bit         pend_we;
  logic [15:0] pend_addr;
  logic [7:0]  pend_data;

  function automatic logic [15:0] echo_addr(input logic [15:0] a);
    if (a >= 16'hE000 && a < 16'hFE00) return a - 16'h2000;
    return a;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("mem_addr",      mem_addr,               e.maddr);
      chk("mem_wdata",     16'(mem_wdata),         16'(e.mwd));
      chk("mem_read_en",   16'(mem_read_en),       16'(e.mre));
      chk("mem_write_en",  16'(mem_write_en),      16'(e.mwe));
      chk("hram_addr",     hram_addr,              e.haddr);
      chk("hram_wdata",    16'(hram_wdata),        16'(e.hwd));
      chk("hram_read_en",  16'(hram_read_en),      16'(e.hre));
      chk("hram_write_en", 16'(hram_write_en),     16'(e.hwe));
      chk("cpu_rdata",     16'(cpu_rdata),         16'(e.crd));
      chk("dma_rdata",     16'(dma_rdata),         16'(e.drd));
      chk("cpu_blocked",   16'(cpu_blocked),       16'(e.blk));
      chk("blocked_count", 16'(blocked_count),     16'(e.cnt));
      chk("dma_error",     16'(dma_error),         16'(e.err));
      cyc++;
    end
  end

  task automatic step(input bit rst, input bit act,
                      input logic [15:0] ca, input logic [7:0] cw, input bit cre, input bit cwe,
                      input logic [15:0] da, input logic [7:0] dw, input bit dre, input bit dwe);
    exp_t e;
    bit own, hr, wr_ok;
    @(posedge clk);
    #1;
    if (pend_we) mem_arr[pend_addr] = pend_data;
    pend_we      = 1'b0;
    reset_n      = rst;
    dma_active   = act;
    cpu_addr     = ca;
    cpu_wdata    = cw;
    cpu_read_en  = cre;
    cpu_write_en = cwe;
    dma_addr     = da;
    dma_wdata    = dw;
    dma_read_en  = dre;
    dma_write_en = dwe;
    e = '0;
    e.crd = 8'hFF;
    if (!rst) begin
      m_a1 = 0; m_a2 = 0; m_cnt = 8'd0; m_err = 0; m_rq = 8'hFF;
      e.drd = 8'hFF;
    end else begin
      own = m_a1 || m_a2;
      hr  = (ca >= 16'hFF80);
      e.drd = m_rq;
      e.cnt = m_cnt;
      e.err = m_err;
      if ((cre || cwe) && hr) begin
        e.haddr = ca; e.hre = cre; e.hwe = cwe; e.hwd = cwe ? cw : 8'h00;
        if (cre) e.crd = ca[7:0] ^ 8'h3C;
      end else if (cre || cwe) begin
        if (!own) begin
          e.maddr = ca; e.mre = cre; e.mwe = cwe; e.mwd = cwe ? cw : 8'h00;
          if (cre) e.crd = mem_arr[ca];
        end else begin
          e.blk = 1'b1;
        end
      end
      if (own) begin
        wr_ok = dwe && !dre && (da >= 16'hFE00) && (da <= 16'hFE9F);
        if (dre || wr_ok) begin
          e.maddr = echo_addr(da); e.mre = dre; e.mwe = wr_ok; e.mwd = wr_ok ? dw : 8'h00;
        end
        if (dre) begin
          e.drd = mem_arr[echo_addr(da)];
          m_rq  = e.drd;
        end
        if (dwe && !wr_ok) m_err = 1;
      end
      if (!own && act) m_cnt = 8'd0;
      else if (e.blk && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      if (e.mwe) begin
        pend_we = 1'b1; pend_addr = e.maddr; pend_data = e.mwd;
      end
      m_a2 = m_a1;
      m_a1 = act;
    end
    sb.push_back(e);
  endtask

  function automatic logic [15:0] rand_cpu_addr();
    case ($urandom_range(0, 3))
      0:       return 16'hC000 + 16'($urandom_range(0, 255));
      1:       return 16'hFF80 + 16'($urandom_range(0, 127));
      2:       return 16'h8000 + 16'($urandom_range(0, 4095));
      default: return 16'($urandom());
    endcase
  endfunction

  function automatic logic [15:0] rand_dma_addr();
    case ($urandom_range(0, 4))
      0:       return 16'hC000 + 16'($urandom_range(0, 255));
      1:       return 16'hE000 + 16'($urandom_range(0, 16'h1DFF));
      2:       return 16'hFE00 + 16'($urandom_range(0, 16'h9F));
      3:       return 16'hFEA0 + 16'($urandom_range(0, 16'h15F));
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    bit act;
    for (int i = 0; i < 65536; i++) mem_arr[i] = 8'($urandom());
    mem_arr[16'hC123] = 8'h5A;
    mem_arr[16'hD100] = 8'hA7;
    pend_we = 0; m_a1 = 0; m_a2 = 0; m_cnt = 0; m_err = 0; m_rq = 8'hFF;
    reset_n = 0; dma_active = 0;
    cpu_addr = 0; cpu_wdata = 0; cpu_read_en = 0; cpu_write_en = 0;
    dma_addr = 0; dma_wdata = 0; dma_read_en = 0; dma_write_en = 0;

    // Reset state, including a CPU access attempted during reset.
    step(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0);
    step(0, 1, 16'hC000, 8'h11, 1, 1, 16'hFE10, 8'h22, 0, 1);
    step(1, 0, 16'hC000, 8'h00, 1, 0, 16'h0000, 8'h00, 0, 0);

    // DMA rises: first cycle CPU still served, second cycle blocked.
    step(1, 1, 16'hC000, 8'h00, 1, 0, 16'hFE00, 8'h33, 0, 1);
    step(1, 1, 16'hC000, 8'h00, 1, 0, 16'h0000, 8'h00, 0, 0);
    // Read C123, write the value to OAM, echo read, illegal write.
    step(1, 1, 16'h0000, 8'h00, 0, 0, 16'hC123, 8'h00, 1, 0);
    step(1, 1, 16'h0000, 8'h00, 0, 0, 16'hFE23, 8'h5A, 0, 1);
    step(1, 1, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0);
    step(1, 1, 16'h0000, 8'h00, 0, 0, 16'hF100, 8'h00, 1, 0);
    step(1, 1, 16'h0000, 8'h00, 0, 0, 16'hC000, 8'h77, 0, 1);
    step(1, 1, 16'h0000, 8'h00, 0, 0, 16'hFE40, 8'h66, 1, 1);
    // Saturation of the drop counter, then HRAM stays reachable.
    for (int i = 0; i < 300; i++)
      step(1, 1, 16'hC000 + 16'(i), 8'(i), 0, 1, 16'h0000, 8'h00, 0, 0);
    step(1, 1, 16'hFF90, 8'hC3, 0, 1, 16'h0000, 8'h00, 0, 0);
    step(1, 1, 16'hFF90, 8'h00, 1, 0, 16'h0000, 8'h00, 0, 0);
    // dma_active falls: blocked through DMA_OWN and RELEASE, then served.
    for (int i = 0; i < 4; i++)
      step(1, 0, 16'hC010, 8'h00, 1, 0, 16'hFE00, 8'h01, 0, 1);
    // Reset in the middle of a transfer, then CPU owns immediately.
    step(1, 1, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0);
    step(1, 1, 16'h0000, 8'h00, 0, 0, 16'hFE05, 8'h9E, 0, 1);
    step(0, 1, 16'hC020, 8'h00, 1, 0, 16'hFE06, 8'h9F, 0, 1);
    step(1, 0, 16'hC020, 8'h00, 1, 0, 16'hFE07, 8'h90, 0, 1);

    // Randomized traffic with DMA bursts and occasional resets.
    act = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) act = ~act;
      step(($urandom_range(0, 599) != 0), act,
           rand_cpu_addr(), 8'($urandom()), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           rand_dma_addr(), 8'($urandom()), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
